// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset controller: sequences IF/ID/EX/MEM/WB over a shared datapath.
// Optional feature macro ILLEGAL_TRAP_EN: illegal decodes park the FSM in a trap state.
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Ins,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             IRWr,
    output logic             PCWr,
    output logic             Branch,
    output logic             Jump,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic [2:0]       ALUctr,
    output logic             ExtOp,
    output logic             MemtoReg,
    output logic             RegWr,
    output logic             MemWr,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EX   = 4'd2,
        S_WB   = 4'd3,
        S_MA   = 4'd4,
        S_MEM  = 4'd5,
        S_LWB  = 4'd6,
        S_BR   = 4'd7,
        S_JP   = 4'd8,
        S_TRAP = 4'd9
    } state_t;

    state_t     state, state_nxt, illegal_dst;
    logic [5:0] op_q, func_q;
    logic [5:0] id_op, id_func;
    logic       id_rtype_ok;
    logic [2:0] rtype_alu;
    logic       retire;
    logic       unused_ins;

    assign id_op      = Ins[31:26];
    assign id_func    = Ins[5:0];
    assign unused_ins = ^Ins[25:6];

    assign id_rtype_ok = (id_func == FN_ADD)  || (id_func == FN_ADDU) ||
                         (id_func == FN_SUB)  || (id_func == FN_SUBU);

`ifdef ILLEGAL_TRAP_EN
    assign illegal_dst = S_TRAP;
`else
    // Illegal decodes retire as a NOP straight back to fetch.
    assign illegal_dst = S_IF;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Decode sees Ins during S_ID; later states use the latched copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            func_q <= '0;
        end else if (state == S_ID) begin
            op_q   <= id_op;
            func_q <= id_func;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IF:  if (mem_ready) state_nxt = S_ID;
            S_ID: begin
                case (id_op)
                    OP_R:         state_nxt = id_rtype_ok ? S_EX : illegal_dst;
                    OP_ORI:       state_nxt = S_EX;
                    OP_LW, OP_SW: state_nxt = S_MA;
                    OP_BEQ:       state_nxt = S_BR;
                    OP_J:         state_nxt = S_JP;
                    default:      state_nxt = illegal_dst;
                endcase
            end
            S_EX:  state_nxt = S_WB;
            S_WB:  state_nxt = S_IF;
            S_MA:  state_nxt = S_MEM;
            S_MEM: begin
                if (mem_ready) state_nxt = (op_q == OP_LW) ? S_LWB : S_IF;
            end
            S_LWB: state_nxt = S_IF;
            S_BR:  state_nxt = S_IF;
            S_JP:  state_nxt = S_IF;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_IF;
        endcase
    end

    always_comb begin
        case (func_q)
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_SUBU: rtype_alu = ALU_SUBU;
            default: rtype_alu = ALU_ADD;
        endcase
    end

    // Outputs are forced low while reset is high so an in-flight access drops immediately.
    always_comb begin
        mem_req  = 1'b0;
        IorD     = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        ALUctr   = ALU_IDLE;
        ExtOp    = 1'b0;
        MemtoReg = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state)
                S_IF: begin
                    mem_req = 1'b1;
                    IRWr    = mem_ready;
                    PCWr    = mem_ready;
                end
                S_EX, S_WB: begin
                    if (op_q == OP_ORI) begin
                        ALUSrc = 1'b1;
                        ALUctr = ALU_OR;
                    end else begin
                        RegDst = 1'b1;
                        ALUctr = rtype_alu;
                    end
                    RegWr = (state == S_WB);
                end
                S_MA, S_MEM: begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                    ALUctr = ALU_ADD;
                    if (state == S_MEM) begin
                        mem_req = 1'b1;
                        IorD    = 1'b1;
                        MemWr   = (op_q == OP_SW);
                    end
                end
                S_LWB: begin
                    MemtoReg = 1'b1;
                    RegWr    = 1'b1;
                end
                S_BR: begin
                    ALUctr = ALU_SUBU;
                    Branch = 1'b1;
                end
                S_JP: begin
                    Jump = 1'b1;
                    PCWr = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // An instruction retires on every re-entry to fetch; trap parking never re-enters.
    assign retire = (state != S_IF) && (state_nxt == S_IF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt <= '0;
        end else if (retire) begin
            instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

endmodule
